// File: rtl/conv1_ctrl.sv
// Raster-scan window controller for a FILTER_SIZE x FILTER_SIZE convolution front end.
// Optional build macro: CONV1_CTRL_RELU_EN (clamps negative channel results to zero).
module conv1_ctrl #(
  parameter int unsigned WIDTH       = 28,
  parameter int unsigned HEIGHT      = 28,
  parameter int unsigned FILTER_SIZE = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               valid_in,
  output logic               in_ready,
  input  logic signed [11:0] conv_out_1,
  input  logic signed [11:0] conv_out_2,
  input  logic signed [11:0] conv_out_3,
  input  logic               out_ready,
  output logic               valid_out,
  output logic signed [11:0] data_out_1,
  output logic signed [11:0] data_out_2,
  output logic signed [11:0] data_out_3,
  output logic [4:0]         out_row,
  output logic [4:0]         out_col,
  output logic               last_out,
  output logic               busy
);

  localparam int unsigned DW = 12;
  localparam int unsigned OW = 5;
  localparam int unsigned CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(FILTER_SIZE - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(FILTER_SIZE - 1);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  typedef struct packed {
    logic signed [DW-1:0] ch1;
    logic signed [DW-1:0] ch2;
    logic signed [DW-1:0] ch3;
    logic [OW-1:0]        row;
    logic [OW-1:0]        col;
    logic                 last;
  } result_t;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  result_t       res_q, res_d;
  logic          valid_q, valid_d;

  logic accept_c;
  logic hit_c;
  logic frame_end_c;

  // Channel shaping applied as a result is captured.
  function automatic logic signed [DW-1:0] shape(input logic signed [DW-1:0] v);
`ifdef CONV1_CTRL_RELU_EN
    shape = v[DW-1] ? '0 : v;
`else
    shape = v;
`endif
  endfunction

  // Upstream is stalled whenever the result register cannot take a new value.
  assign in_ready    = (state_q == ACTIVE) && (!valid_q || out_ready);
  assign accept_c    = valid_in && in_ready;
  assign hit_c       = accept_c && (row_q >= ROW_MIN) && (col_q >= COL_MIN);
  assign frame_end_c = accept_c && (row_q == ROW_LAST) && (col_q == COL_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACTIVE;
      ACTIVE:  if (frame_end_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Raster position of the next pixel to be accepted.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if ((state_q == IDLE) && start) begin
      col_d = '0;
      row_d = '0;
    end else if (accept_c) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // Result register: a window hit overrides a same-cycle drain.
  always_comb begin
    res_d   = res_q;
    valid_d = valid_q;
    if (hit_c) begin
      res_d.ch1  = shape(conv_out_1);
      res_d.ch2  = shape(conv_out_2);
      res_d.ch3  = shape(conv_out_3);
      res_d.row  = OW'(row_q - ROW_MIN);
      res_d.col  = OW'(col_q - COL_MIN);
      res_d.last = frame_end_c;
      valid_d    = 1'b1;
    end else if (out_ready) begin
      valid_d    = 1'b0;
      res_d.last = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      res_q   <= res_d;
      valid_q <= valid_d;
    end
  end

  assign valid_out  = valid_q;
  assign data_out_1 = res_q.ch1;
  assign data_out_2 = res_q.ch2;
  assign data_out_3 = res_q.ch3;
  assign out_row    = res_q.row;
  assign out_col    = res_q.col;
  assign last_out   = res_q.last;
  assign busy       = (state_q == ACTIVE);

endmodule

// File: tb/tb_conv1_ctrl.sv
// Randomized bench for conv1_ctrl against a pixel-index / pending-result reference model.
module tb_conv1_ctrl;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int FS   = 5;
  localparam int MAPW = W - FS + 1;
  localparam int NRES = (H - FS + 1) * MAPW;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic               valid_in;
  logic               in_ready;
  logic signed [11:0] conv_out_1, conv_out_2, conv_out_3;
  logic               out_ready;
  logic               valid_out;
  logic signed [11:0] data_out_1, data_out_2, data_out_3;
  logic [4:0]         out_row, out_col;
  logic               last_out;
  logic               busy;

  conv1_ctrl #(.WIDTH(W), .HEIGHT(H), .FILTER_SIZE(FS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .valid_in(valid_in), .in_ready(in_ready),
    .conv_out_1(conv_out_1), .conv_out_2(conv_out_2), .conv_out_3(conv_out_3),
    .out_ready(out_ready), .valid_out(valid_out),
    .data_out_1(data_out_1), .data_out_2(data_out_2), .data_out_3(data_out_3),
    .out_row(out_row), .out_col(out_col), .last_out(last_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Reference model: frame progress as a pixel index plus one pending-result slot.
  bit m_active, m_pend;
  int m_pix, n_out, n_drained;
  int e_d1, e_d2, e_d3, e_row, e_col;
  bit e_last, e_forced, need34;

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
    end
  endtask

  function automatic int relu(input int v);
`ifdef CONV1_CTRL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // One clock: drive, check presented outputs, advance the model.
  task automatic step(input bit st, input bit vin, input bit ordy, input bit f34);
    int c1, c2, c3, r, c, exp34;
    bit exp_rdy, acc, drained;
    @(negedge clk);
    c1 = f34 ? -37 : int'($urandom_range(4095, 0)) - 2048;
    c2 = f34 ? 100 : int'($urandom_range(4095, 0)) - 2048;
    c3 = int'($urandom_range(4095, 0)) - 2048;
    start = st; valid_in = vin; out_ready = ordy;
    conv_out_1 = 12'(c1); conv_out_2 = 12'(c2); conv_out_3 = 12'(c3);
    #1;
    exp_rdy = m_active && (!m_pend || ordy);
    chk("in_ready", int'(in_ready), int'(exp_rdy));
    chk("busy", int'(busy), int'(m_active));
    chk("valid_out", int'(valid_out), int'(m_pend));
    if (m_pend) begin
      chk("data1", int'($signed(data_out_1)), e_d1);
      chk("data2", int'($signed(data_out_2)), e_d2);
      chk("data3", int'($signed(data_out_3)), e_d3);
      chk("row", int'(out_row), e_row);
      chk("col", int'(out_col), e_col);
      chk("last", int'(last_out), int'(e_last));
      if (e_forced) begin
`ifdef CONV1_CTRL_RELU_EN
        exp34 = 0;
`else
        exp34 = -37;
`endif
        chk("neg_ch1", int'($signed(data_out_1)), exp34);
        chk("pos_ch2", int'($signed(data_out_2)), 100);
      end
    end else begin
      chk("last_idle", int'(last_out), 0);
    end
    drained = m_pend && ordy;
    if (drained) begin
      chk("order", int'(out_row) * MAPW + int'(out_col), n_out);
      n_out = (n_out == NRES - 1) ? 0 : n_out + 1;
      n_drained++;
    end
    acc = vin && exp_rdy;
    if (acc) begin
      r = m_pix / W;
      c = m_pix % W;
      if (r >= FS - 1 && c >= FS - 1) begin
        m_pend = 1; e_forced = f34;
        if (f34) need34 = 0;
        e_d1 = relu(c1); e_d2 = relu(c2); e_d3 = relu(c3);
        e_row = r - (FS - 1); e_col = c - (FS - 1);
        e_last = (r == H - 1) && (c == W - 1);
      end else if (drained) begin
        m_pend = 0;
      end
      m_pix++;
      if (m_pix == W * H) m_active = 0;
    end else if (drained) begin
      m_pend = 0;
    end
    if (st && !m_active) begin
      m_active = 1;
      m_pix = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 0; valid_in = 1; out_ready = 1;
    #2 rst_n = 0;
    #1;
    chk("rst_valid", int'(valid_out), 0);
    chk("rst_d1", int'($signed(data_out_1)), 0);
    chk("rst_d2", int'($signed(data_out_2)), 0);
    chk("rst_d3", int'($signed(data_out_3)), 0);
    chk("rst_row", int'(out_row), 0);
    chk("rst_col", int'(out_col), 0);
    chk("rst_last", int'(last_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(in_ready), 0);
    m_active = 0; m_pend = 0; m_pix = 0; n_out = 0; e_forced = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (3) step(0, 1, 1, 0);
  endtask

  // mode 0 streaming, 1 gapped + stall + mid-frame start, 2 reset at pixel 300, 3 restart with final result pending
  task automatic run_frame(input int mode);
    int base, stall;
    bit sent400, stalled, did26, done, vin, ordy, st, f;
    base = n_drained; stall = 0; sent400 = 0; stalled = 0; did26 = 0; done = 0;
    step(1, 0, 1, 0);
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (!m_active && !m_pend) begin
        done = 1;
        break;
      end
      vin = 1; ordy = 1; st = 0;
      if (mode == 1 || mode == 2) begin
        vin  = 1'($urandom_range(1, 0));
        ordy = ($urandom_range(3, 0) != 0);
      end
      if (mode == 2 && m_pix == 300) begin
        do_reset();
        return;
      end
      if (mode == 1) begin
        if (!stalled && m_pend && m_pix > 150) begin
          stall = 10; stalled = 1;
        end
        if (m_pix == 400 && !sent400) begin
          st = 1; sent400 = 1;
        end
      end
      if (mode == 3 && !did26 && !m_active && m_pend) begin
        did26 = 1; st = 1; stall = 4;
      end
      if (stall > 0) begin
        ordy = 0; stall--;
      end
      f = need34 && m_active && ((m_pix / W) >= FS - 1) && ((m_pix % W) >= FS - 1);
      step(st, vin, ordy, f);
    end
    chk("frame_done", int'(done), 1);
    chk("nres", n_drained - base, (mode == 3) ? 2 * NRES : NRES);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    m_active = 0; m_pend = 0; m_pix = 0; n_out = 0; n_drained = 0;
    e_d1 = 0; e_d2 = 0; e_d3 = 0; e_row = 0; e_col = 0; e_last = 0; e_forced = 0; need34 = 0;
    rst_n = 0; start = 0; valid_in = 0; out_ready = 0;
    conv_out_1 = '0; conv_out_2 = '0; conv_out_3 = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("init_valid", int'(valid_out), 0);
    chk("init_busy", int'(busy), 0);
    chk("init_ready", int'(in_ready), 0);
    chk("init_last", int'(last_out), 0);
    @(negedge clk);
    rst_n = 1;
    run_frame(0);
    need34 = 1;
    run_frame(1);
    chk("neg_hit_seen", int'(need34), 0);
    run_frame(2);
    run_frame(0);
    run_frame(3);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
